// File: rtl/mem_dma_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_dma_pkg
// Brief   : Shared state encoding and memory-port constants for mem_block_copier
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic       MODE_COPY = 1'b0;
  localparam logic       MODE_FILL = 1'b1;

  localparam logic [3:0] WB_NONE   = 4'b0000;
  localparam logic [3:0] WB_WORD   = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/mem_block_copier.sv
//------------------------------------------------------------------------------
// Module  : mem_block_copier
// Brief   : Word-granular block copy / fill initiator on a single-port RAM port
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_block_copier
  import mem_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_in,
  input  logic                  mode_in,
  input  logic [ADDR_WIDTH-1:0] src_in,
  input  logic [ADDR_WIDTH-1:0] dst_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic [31:0]           pattern_in,
  input  logic                  abort_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic                  mem_enable_out,
  output logic [3:0]            mem_wb_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in
);

  localparam logic [ADDR_WIDTH-1:0] c_WORD_BYTES = ADDR_WIDTH'(4);
  localparam logic [LEN_WIDTH-1:0]  c_LEN_ONE    = LEN_WIDTH'(1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_mode;
  logic                  r_error;
  logic [ADDR_WIDTH-1:0] r_src;
  logic [ADDR_WIDTH-1:0] r_dst;
  logic [LEN_WIDTH-1:0]  r_count;
  logic [31:0]           r_pattern;

  logic                  w_len_zero;
  logic                  w_reject;

  // A zero-length request completes quietly even if its addresses are misaligned.
  assign w_len_zero = (len_in == '0);
  assign w_reject   = !w_len_zero &&
                      (((mode_in == MODE_COPY) && (src_in[1:0] != 2'b00)) ||
                       (dst_in[1:0] != 2'b00));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode    <= MODE_COPY;
      r_error   <= 1'b0;
      r_src     <= '0;
      r_dst     <= '0;
      r_count   <= '0;
      r_pattern <= '0;
    end else begin
      if (r_state == IDLE && start_in) begin
        r_mode    <= mode_in;
        r_error   <= w_reject;
        r_src     <= src_in;
        r_dst     <= dst_in;
        r_count   <= len_in;
        r_pattern <= pattern_in;
      end else if (r_state == WRITE) begin
        r_src   <= r_src + c_WORD_BYTES;
        r_dst   <= r_dst + c_WORD_BYTES;
        r_count <= r_count - c_LEN_ONE;
      end
    end
  end

  always_comb begin
    w_next_state   = r_state;
    busy_out       = 1'b0;
    done_out       = 1'b0;
    error_out      = 1'b0;
    mem_enable_out = 1'b0;
    mem_wb_out     = WB_NONE;
    mem_addr_out   = '0;
    mem_data_out   = '0;

    case (r_state)
      IDLE: begin
        if (start_in) begin
          if (w_len_zero || w_reject) begin
            w_next_state = DONE;
          end else if (mode_in == MODE_FILL) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = READ;
          end
        end
      end
      READ: begin
        busy_out       = 1'b1;
        mem_enable_out = 1'b1;
        mem_addr_out   = r_src;
        w_next_state   = abort_in ? DONE : WRITE;
      end
      WRITE: begin
        busy_out       = 1'b1;
        mem_enable_out = 1'b1;
        mem_wb_out     = WB_WORD;
        mem_addr_out   = r_dst;
        // Copy data is the RAM's registered read from the preceding READ cycle.
        mem_data_out   = (r_mode == MODE_FILL) ? r_pattern : mem_data_in;
        if (abort_in || r_count == c_LEN_ONE) begin
          w_next_state = DONE;
        end else begin
          w_next_state = (r_mode == MODE_FILL) ? WRITE : READ;
        end
      end
      DONE: begin
        done_out     = 1'b1;
        error_out    = r_error;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_block_copier.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_block_copier
// Brief   : Self-checking bench with a RAM model and a word-level transfer model
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_block_copier;

  localparam int c_WORDS = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_in = 1'b0;
  logic        mode_in = 1'b0;
  logic [31:0] src_in = '0;
  logic [31:0] dst_in = '0;
  logic [15:0] len_in = '0;
  logic [31:0] pattern_in = '0;
  logic        abort_in = 1'b0;
  logic        busy_out, done_out, error_out, mem_enable_out;
  logic [3:0]  mem_wb_out;
  logic [31:0] mem_addr_out, mem_data_out;
  logic [31:0] mem_data_in = '0;

  logic [31:0] ram [c_WORDS];
  logic [31:0] exp_mem [c_WORDS];
  logic        pl_we = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_data = '0;
  logic [31:0] w_merge;

  int errors = 0;
  int checks = 0;

  mem_block_copier dut (
    .clock          (clock),
    .reset          (reset),
    .start_in       (start_in),
    .mode_in        (mode_in),
    .src_in         (src_in),
    .dst_in         (dst_in),
    .len_in         (len_in),
    .pattern_in     (pattern_in),
    .abort_in       (abort_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .error_out      (error_out),
    .mem_enable_out (mem_enable_out),
    .mem_wb_out     (mem_wb_out),
    .mem_addr_out   (mem_addr_out),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in)
  );

  always #5 clock = ~clock;

  // Single-port RAM: byte strobes (bit0 = MSB byte), registered read data.
  always @(posedge clock) begin
    if (pl_we) begin
      ram[pl_idx] <= pl_data;
    end else if (mem_enable_out) begin
      w_merge = ram[mem_addr_out[11:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wb_out[b]) w_merge[31-8*b -: 8] = mem_data_out[31-8*b -: 8];
      ram[mem_addr_out[11:2]] <= w_merge;
      mem_data_in <= ram[mem_addr_out[11:2]];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clock);
    pl_we = 1'b1; pl_idx = idx; pl_data = data;
    exp_mem[idx] = data;
    @(posedge clock); #1;
    pl_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int mism = 0;
    for (int i = 0; i < c_WORDS; i++)
      if (ram[i] !== exp_mem[i]) mism++;
    chk({tag, " mem_mismatches"}, mism, 0);
  endtask

  function automatic int widx(input logic [31:0] addr, input int i);
    return (int'(addr >> 2) + i) % c_WORDS;
  endfunction

  // Model: done cycle and the number of words written follow from the
  // request alone; copies are applied strictly in ascending word order.
  task automatic run_op(input string tag, input bit mode, input logic [31:0] src,
                        input logic [31:0] dst, input logic [15:0] len,
                        input logic [31:0] pat, input int abort_at, input int restart_at);
    bit exp_err;
    int exp_done, exp_words, full;
    int done_cyc = -1, busy_cnt = 0, en_cnt = 0, data_bad = 0;
    logic err_seen = 1'b0;

    exp_err = (len != 0) && (((mode == 1'b0) && (src[1:0] != 2'b00)) || (dst[1:0] != 2'b00));
    if (len == 0 || exp_err) begin
      exp_done = 1; exp_words = 0;
    end else begin
      full = mode ? int'(len) + 1 : 2 * int'(len) + 1;
      if (abort_at > 0 && abort_at < full) begin
        exp_done = abort_at + 1;
        exp_words = mode ? abort_at : abort_at / 2;
      end else begin
        exp_done = full; exp_words = int'(len);
      end
    end
    for (int i = 0; i < exp_words; i++)
      exp_mem[widx(dst, i)] = mode ? pat : exp_mem[widx(src, i)];

    @(negedge clock);
    mode_in = mode; src_in = src; dst_in = dst; len_in = len; pattern_in = pat;
    start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clock);
      abort_in = (k == abort_at);
      start_in = (k == restart_at);
      if (busy_out) busy_cnt++;
      if (mem_enable_out) en_cnt++;
      if (mem_wb_out != 4'hF && mem_data_out != 32'h0) data_bad++;
      if (done_out) begin
        done_cyc = k; err_seen = error_out;
        break;
      end
      @(posedge clock); #1;
    end
    abort_in = 1'b0; start_in = 1'b0;
    @(posedge clock); #1;

    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " error"}, {31'b0, err_seen}, {31'b0, exp_err});
    chk({tag, " busy_cycles"}, busy_cnt, exp_done - 1);
    chk({tag, " enable_cycles"}, en_cnt, exp_done - 1);
    chk({tag, " data_zero_outside_write"}, data_bad, 0);
    chk({tag, " idle_after_done"}, {30'b0, busy_out, done_out}, 32'h0);
    check_mem(tag);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " busy"}, {31'b0, busy_out}, 0);
    chk({tag, " done_err"}, {30'b0, done_out, error_out}, 0);
    chk({tag, " enable_wb"}, {27'b0, mem_enable_out, mem_wb_out}, 0);
    chk({tag, " addr"}, mem_addr_out, 0);
    chk({tag, " data"}, mem_data_out, 0);
  endtask

  initial begin
    for (int i = 0; i < c_WORDS; i++) exp_mem[i] = 'x;
    #1;
    check_outputs_zero("reset_held");
    #20;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    check_outputs_zero("after_reset");

    for (int i = 0; i < c_WORDS; i++) poke(i, $urandom);

    // Directed copy of four known words.
    poke('h100 >> 2, 32'h11111111);
    poke('h104 >> 2, 32'h22222222);
    poke('h108 >> 2, 32'h33333333);
    poke('h10C >> 2, 32'h44444444);
    run_op("copy4", 1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 0, 0);
    chk("copy4 word3", ram['h20C >> 2], 32'h44444444);

    run_op("fill3", 1'b1, 32'h0, 32'h40, 16'd3, 32'hDEADBEEF, 0, 0);
    run_op("len0", 1'b0, 32'h100, 32'h300, 16'd0, 32'h0, 0, 0);
    run_op("misaligned_src", 1'b0, 32'h102, 32'h300, 16'd4, 32'h0, 0, 0);
    run_op("misaligned_dst", 1'b1, 32'h0, 32'h301, 16'd2, 32'h5A5A5A5A, 0, 0);

    // Abort during the WRITE of word 2 (cycle 6) of an 8-word copy.
    run_op("abort_copy", 1'b0, 32'h400, 32'h500, 16'd8, 32'h0, 6, 0);
    run_op("abort_fill", 1'b1, 32'h0, 32'h600, 16'd10, 32'hCAFEF00D, 3, 0);

    // Overlapping copy replicates the first word; start pulsed while busy.
    poke(0, 32'hAAAA0001); poke(1, 32'hBBBB0002); poke(2, 32'hCCCC0003); poke(3, 32'hDDDD0004);
    run_op("overlap", 1'b0, 32'h0, 32'h4, 16'd3, 32'h0, 0, 3);
    chk("overlap word3", ram[3], 32'hAAAA0001);

    run_op("wrap_fill", 1'b1, 32'h0, 32'hFFFF_FFF8, 16'd4, 32'h01234567, 0, 0);

    for (int t = 0; t < 6; t++) begin
      run_op($sformatf("rand%0d", t), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023) * 4), 32'($urandom_range(0, 1023) * 4),
             16'($urandom_range(1, 12)), $urandom, 0, 0);
    end

    // Asynchronous reset in the middle of cycle 5 (READ of word 2).
    @(negedge clock);
    mode_in = 1'b0; src_in = 32'h700; dst_in = 32'h780; len_in = 16'd8; start_in = 1'b1;
    @(posedge clock); #1;
    start_in = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    for (int i = 0; i < 2; i++) exp_mem[widx(32'h780, i)] = exp_mem[widx(32'h700, i)];
    @(negedge clock);
    reset = 1'b0;
    run_op("post_reset_copy", 1'b0, 32'h800, 32'h880, 16'd5, 32'h0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_block_copier.md
# mem_block_copier

Memory-port initiator that moves blocks of 32-bit words through the single-port RAM's access port, driving enable, byte-write strobes and address and consuming the RAM's one-cycle registered read data. It sits between a control source (core-side register or testbench) and the memory port. It supports block copy (read then write per word) and block fill (write a constant pattern). It replaces ad-hoc memory preload and clear sequences in the packet simulator.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte-address width driven on the memory port
- LEN_WIDTH, 16, width of the word-count field

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- start_in  in  1  request; sampled only in IDLE
- mode_in  in  1  0 = copy, 1 = fill; sampled with start_in
- src_in  in  ADDR_WIDTH  source byte address (copy only)
- dst_in  in  ADDR_WIDTH  destination byte address
- len_in  in  LEN_WIDTH  transfer length in 32-bit words
- pattern_in  in  32  fill word; sampled with start_in
- abort_in  in  1  terminate an active transfer
- busy_out  out  1  transfer in progress
- done_out  out  1  one-cycle completion pulse
- error_out  out  1  one-cycle pulse, coincident with done_out, on rejected request
- mem_enable_out  out  1  memory access enable
- mem_wb_out  out  4  byte-write strobes; bit0 = bits 31:24 at addr+0 … bit3 = bits 7:0 at addr+3
- mem_addr_out  out  ADDR_WIDTH  byte address to memory
- mem_data_out  out  32  write data to memory
- mem_data_in  in  32  memory read data, valid one cycle after address is presented

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: memory outputs idle (enable 0, wb 0000). On start_in, latch mode, src, dst, len and pattern.
  - len_in = 0 -> DONE, no memory access.
  - src_in[1:0] ≠ 0 (copy) or dst_in[1:0] ≠ 0 -> DONE with error flag, no memory access.
  - Otherwise copy -> READ, fill -> WRITE.
- READ: enable 1, wb 0000, addr = src pointer. Next state WRITE.
- WRITE: enable 1, wb 1111, addr = dst pointer.
  - Data is mem_data_in (copy, combinational pass-through) or pattern (fill).
  - Both pointers advance by 4 and the remaining count decrements by 1.
  - If the count reaches 0 -> DONE. Otherwise -> READ (copy) or WRITE (fill).
- DONE: done_out = 1; error_out = 1 if rejected. Next state IDLE.
- abort_in high in READ or WRITE -> DONE next cycle. The access driven in the abort cycle still completes. error_out stays 0 on abort.
- start_in outside IDLE is ignored; there is no queuing.
- Pointers wrap modulo 2^ADDR_WIDTH.
- Copy is strictly ascending. Overlapping regions with dst in (src, src+4·len) replicate data, and that is the defined behaviour.
- mem_data_out is 0 whenever the state is not WRITE.

## Timing
- Reset values: state IDLE; busy_out, done_out, error_out, mem_enable_out 0; mem_wb_out 0000; mem_addr_out and mem_data_out 0; pointers and count 0.
- Start sampled at edge 0. Copy of N words: READ/WRITE alternate in cycles 1..2N, DONE in cycle 2N+1, IDLE in 2N+2.
- Fill of N words: WRITE in cycles 1..N, DONE in N+1.
- Zero length or error: DONE in cycle 1.
- busy_out is high exactly in READ and WRITE.
- A new start is accepted in the first IDLE cycle after DONE.
- Read-after-write: a READ following a WRITE to the same address returns the newly written word, because the RAM commits the write at the edge ending the WRITE cycle.
- Reset asserted mid-transfer forces IDLE and the reset values immediately, without waiting for a clock. No done_out is produced. Partially written memory is left as is.

## Structure
- Package mem_dma_pkg holds:
  - state enum (IDLE, READ, WRITE, DONE)
  - MODE_COPY = 1'b0, MODE_FILL = 1'b1
  - WB_NONE = 4'b0000, WB_WORD = 4'b1111
- Single module, no sub-modules. Pointer and count registers are inline.

## Test plan
- Copy src=0x100, dst=0x200, len=4, memory 0x100..0x10F = 11111111, 22222222, 33333333, 44444444 -> same words at 0x200..0x20F; done_out in cycle 9; busy_out high in cycles 1–8.
- Fill dst=0x40, len=3, pattern=DEADBEEF -> 0x40, 0x44, 0x48 = DEADBEEF; 0x4C unchanged; done_out in cycle 4.
- len=0, and separately src=0x102 in copy mode -> no mem_enable_out assertion; done_out in cycle 1; error_out 0 and 1 respectively.
- Abort during the WRITE of word 2 of an 8-word copy -> words 0–2 written, word 3 untouched; done_out the next cycle; error_out 0.
- Overlapping copy src=0x0, dst=0x4, len=3 with memory A, B, C, D -> memory A, A, A, A; also start_in pulsed while busy is ignored.
- Async reset asserted mid-copy between clock edges -> all outputs 0 immediately; the next start runs normally.
